// File: rtl/multicycle_control_pkg.sv
// Shared constants for the multi-cycle MIPS main control FSM.
//   - opcode values decoded in DECODE / MEMADR / BRANCH
//   - 4-bit state encoding (codes 12..15 unused)
//   - ALUop, ALUSrcB and PCSrc select encodings
//   - is_supported_op(): true for every opcode the FSM executes
package multicycle_control_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXECUTE = 4'd6,
    S_ALUWB   = 4'd7,
    S_BRANCH  = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JUMP    = 4'd11
  } state_t;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] ALUSRCB_REG   = 2'b00;
  localparam logic [1:0] ALUSRCB_FOUR  = 2'b01;
  localparam logic [1:0] ALUSRCB_IMM   = 2'b10;
  localparam logic [1:0] ALUSRCB_IMMSH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  function automatic logic is_supported_op(input logic [5:0] op);
    case (op)
      OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_ADDI, OP_J: is_supported_op = 1'b1;
      default:                                               is_supported_op = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_control.sv
// Main control FSM of the multi-cycle MIPS datapath.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   Op[5:0]           instruction opcode (IR[31:26])
//   Zero              ALU zero flag (branch decision)
//   mem_ready         memory finishes the current access this cycle
//   ALUop[1:0]        00 add, 01 subtract, 10 use funct
//   IorD, ALUSrcA, RegDst, MemtoReg, ALUSrcB[1:0], PCSrc[1:0]  mux selects
//   IRWrite, MemWrite, RegWrite, PCEn                          write enables
//   illegal_op        one-cycle pulse in DECODE for an unsupported opcode
//   state[3:0]        current state code (debug)
// Outputs are decoded from the current state (some qualified by mem_ready,
// Zero or Op); the write enables are gated by rst_n so nothing is written
// while reset is held.
module multicycle_control
  import multicycle_control_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] Op,
  input  logic       Zero,
  input  logic       mem_ready,
  output logic [1:0] ALUop,
  output logic       IorD,
  output logic       ALUSrcA,
  output logic       RegDst,
  output logic       MemtoReg,
  output logic [1:0] ALUSrcB,
  output logic [1:0] PCSrc,
  output logic       IRWrite,
  output logic       MemWrite,
  output logic       RegWrite,
  output logic       PCEn,
  output logic       illegal_op,
  output logic [3:0] state
);

  state_t state_reg;
  state_t state_next;

  logic ir_write_next;
  logic mem_write_next;
  logic reg_write_next;
  logic pc_en_next;
  logic illegal_next;

  // Next-state logic
  always_comb begin
    state_next = S_FETCH;
    case (state_reg)
      S_FETCH:   state_next = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (Op)
          OP_LW, OP_SW:   state_next = S_MEMADR;
          OP_RTYPE:       state_next = S_EXECUTE;
          OP_BEQ, OP_BNE: state_next = S_BRANCH;
          OP_ADDI:        state_next = S_ADDIEX;
          OP_J:           state_next = S_JUMP;
          default:        state_next = S_FETCH;
        endcase
      end
      S_MEMADR:  state_next = (Op == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:   state_next = mem_ready ? S_MEMWB : S_MEMRD;
      S_MEMWB:   state_next = S_FETCH;
      S_MEMWR:   state_next = mem_ready ? S_FETCH : S_MEMWR;
      S_EXECUTE: state_next = S_ALUWB;
      S_ALUWB:   state_next = S_FETCH;
      S_BRANCH:  state_next = S_FETCH;
      S_ADDIEX:  state_next = S_ADDIWB;
      S_ADDIWB:  state_next = S_FETCH;
      S_JUMP:    state_next = S_FETCH;
      default:   state_next = S_FETCH;  // unused codes recover to FETCH
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= S_FETCH;
    end else begin
      state_reg <= state_next;
    end
  end

  // Output decode: flat case on the current state, everything defaults to 0
  always_comb begin
    IorD           = 1'b0;
    ALUSrcA        = 1'b0;
    RegDst         = 1'b0;
    MemtoReg       = 1'b0;
    ALUSrcB        = ALUSRCB_REG;
    PCSrc          = PCSRC_ALU;
    ALUop          = ALUOP_ADD;
    ir_write_next  = 1'b0;
    mem_write_next = 1'b0;
    reg_write_next = 1'b0;
    pc_en_next     = 1'b0;
    illegal_next   = 1'b0;
    case (state_reg)
      S_FETCH: begin
        ALUSrcB       = ALUSRCB_FOUR;
        ir_write_next = mem_ready;
        pc_en_next    = mem_ready;
      end
      S_DECODE: begin
        ALUSrcB      = ALUSRCB_IMMSH;
        illegal_next = ~is_supported_op(Op);
      end
      S_MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = ALUSRCB_IMM;
      end
      S_MEMRD: begin
        IorD = 1'b1;
      end
      S_MEMWB: begin
        MemtoReg       = 1'b1;
        reg_write_next = 1'b1;
      end
      S_MEMWR: begin
        IorD           = 1'b1;
        mem_write_next = 1'b1;  // held for the whole wait
      end
      S_EXECUTE: begin
        ALUSrcA = 1'b1;
        ALUop   = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        RegDst         = 1'b1;
        reg_write_next = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA    = 1'b1;
        ALUop      = ALUOP_SUB;
        PCSrc      = PCSRC_ALUOUT;
        pc_en_next = (Op == OP_BNE) ? ~Zero : Zero;
      end
      S_ADDIEX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = ALUSRCB_IMM;
      end
      S_ADDIWB: begin
        reg_write_next = 1'b1;
      end
      S_JUMP: begin
        PCSrc      = PCSRC_JUMP;
        pc_en_next = 1'b1;
      end
      default: begin
      end
    endcase
  end

  // Enables are masked while reset is asserted so an abandoned instruction
  // cannot leak a write during the reset window.
  assign IRWrite    = rst_n & ir_write_next;
  assign MemWrite   = rst_n & mem_write_next;
  assign RegWrite   = rst_n & reg_write_next;
  assign PCEn       = rst_n & pc_en_next;
  assign illegal_op = rst_n & illegal_next;
  assign state      = state_reg;

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: each stimulus cycle pushes the
// hand-computed expected output vector; a monitor pops and compares on the
// falling edge.
module tb_multicycle_control;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] Op;
  logic       Zero;
  logic       mem_ready;
  logic [1:0] ALUop;
  logic       IorD, ALUSrcA, RegDst, MemtoReg;
  logic [1:0] ALUSrcB, PCSrc;
  logic       IRWrite, MemWrite, RegWrite, PCEn, illegal_op;
  logic [3:0] state;

  multicycle_control dut (
    .clk(clk), .rst_n(rst_n), .Op(Op), .Zero(Zero), .mem_ready(mem_ready),
    .ALUop(ALUop), .IorD(IorD), .ALUSrcA(ALUSrcA), .RegDst(RegDst),
    .MemtoReg(MemtoReg), .ALUSrcB(ALUSrcB), .PCSrc(PCSrc),
    .IRWrite(IRWrite), .MemWrite(MemWrite), .RegWrite(RegWrite),
    .PCEn(PCEn), .illegal_op(illegal_op), .state(state)
  );

  always #5 clk = ~clk;

  localparam logic [5:0] RT = 6'b000000, LW = 6'b100011, SW = 6'b101011;
  localparam logic [5:0] BEQ = 6'b000100, BNE = 6'b000101, ADDI = 6'b001000;
  localparam logic [5:0] JMP = 6'b000010, BAD = 6'b111111;

  // vector layout: state[4] | IorD ALUSrcA RegDst MemtoReg ALUSrcB[2] PCSrc[2] ALUop[2]
  //                | IRWrite MemWrite RegWrite PCEn illegal_op
  typedef struct {
    logic [18:0] v;
    string       nm;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Hand-written select table, one row per state code
  function automatic logic [9:0] sel_for(input logic [3:0] st);
    case (st)
      4'd0:    sel_for = 10'b0000_01_00_00;
      4'd1:    sel_for = 10'b0000_11_00_00;
      4'd2:    sel_for = 10'b0100_10_00_00;
      4'd3:    sel_for = 10'b1000_00_00_00;
      4'd4:    sel_for = 10'b0001_00_00_00;
      4'd5:    sel_for = 10'b1000_00_00_00;
      4'd6:    sel_for = 10'b0100_00_00_10;
      4'd7:    sel_for = 10'b0010_00_00_00;
      4'd8:    sel_for = 10'b0100_00_01_01;
      4'd9:    sel_for = 10'b0100_10_00_00;
      4'd10:   sel_for = 10'b0000_00_00_00;
      4'd11:   sel_for = 10'b0000_00_10_00;
      default: sel_for = 10'b0000_00_00_00;
    endcase
  endfunction

  // One clock of stimulus: drive inputs, queue what the outputs must be
  task automatic cyc(input logic rn, input logic mr, input logic z,
                     input logic [5:0] op, input logic [3:0] st,
                     input logic [4:0] en, input string nm);
    exp_t e;
    rst_n     = rn;
    mem_ready = mr;
    Zero      = z;
    Op        = op;
    e.v  = {st, sel_for(st), en};
    e.nm = nm;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  // Monitor
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      logic [18:0] act;
      e = exp_q.pop_front();
      act = {state, IorD, ALUSrcA, RegDst, MemtoReg, ALUSrcB, PCSrc, ALUop,
             IRWrite, MemWrite, RegWrite, PCEn, illegal_op};
      checks++;
      if (act !== e.v) begin
        errors++;
        $display("FAIL %s: actual=%b required=%b", e.nm, act, e.v);
      end else begin
        $display("ok   %s: %b", e.nm, act);
      end
    end
  end

  initial begin
    rst_n = 1'b0; mem_ready = 1'b1; Zero = 1'b0; Op = RT;
    repeat (2) @(posedge clk);
    #1;
    cyc(0, 1, 0, RT, 4'd0, 5'b00000, "reset_hold");

    // lw, no wait states, then one MEMRD stall
    cyc(1, 1, 0, LW, 4'd0, 5'b10010, "lw_fetch");
    cyc(1, 1, 0, LW, 4'd1, 5'b00000, "lw_decode");
    cyc(1, 1, 0, LW, 4'd2, 5'b00000, "lw_memadr");
    cyc(1, 1, 0, LW, 4'd3, 5'b00000, "lw_memrd");
    cyc(1, 1, 0, LW, 4'd4, 5'b00100, "lw_memwb");
    cyc(1, 1, 0, LW, 4'd0, 5'b10010, "lw2_fetch");
    cyc(1, 1, 0, LW, 4'd1, 5'b00000, "lw2_decode");
    cyc(1, 0, 0, LW, 4'd2, 5'b00000, "lw2_memadr_mr_ignored");
    cyc(1, 0, 0, LW, 4'd3, 5'b00000, "lw2_memrd_wait");
    cyc(1, 1, 0, LW, 4'd3, 5'b00000, "lw2_memrd_done");
    cyc(1, 1, 0, LW, 4'd4, 5'b00100, "lw2_memwb");

    // R-type
    cyc(1, 1, 0, RT, 4'd0, 5'b10010, "r_fetch");
    cyc(1, 1, 0, RT, 4'd1, 5'b00000, "r_decode");
    cyc(1, 1, 0, RT, 4'd6, 5'b00000, "r_execute");
    cyc(1, 1, 0, RT, 4'd7, 5'b00100, "r_aluwb");

    // beq taken, bne not taken (Zero=1)
    cyc(1, 1, 1, BEQ, 4'd0, 5'b10010, "beq_fetch");
    cyc(1, 1, 1, BEQ, 4'd1, 5'b00000, "beq_decode");
    cyc(1, 1, 1, BEQ, 4'd8, 5'b00010, "beq_branch_taken");
    cyc(1, 1, 1, BNE, 4'd0, 5'b10010, "bne_fetch");
    cyc(1, 1, 1, BNE, 4'd1, 5'b00000, "bne_decode");
    cyc(1, 1, 1, BNE, 4'd8, 5'b00000, "bne_branch_not_taken");
    cyc(1, 1, 0, BNE, 4'd0, 5'b10010, "bne2_fetch");
    cyc(1, 1, 0, BNE, 4'd1, 5'b00000, "bne2_decode");
    cyc(1, 1, 0, BNE, 4'd8, 5'b00010, "bne2_branch_taken");

    // FETCH stalled 3 cycles, then a jump
    cyc(1, 0, 0, JMP, 4'd0, 5'b00000, "fetch_wait1");
    cyc(1, 0, 0, JMP, 4'd0, 5'b00000, "fetch_wait2");
    cyc(1, 0, 0, JMP, 4'd0, 5'b00000, "fetch_wait3");
    cyc(1, 1, 0, JMP, 4'd0, 5'b10010, "fetch_done");
    cyc(1, 0, 0, JMP, 4'd1, 5'b00000, "j_decode");
    cyc(1, 0, 0, JMP, 4'd11, 5'b00010, "j_jump");

    // illegal opcode
    cyc(1, 1, 0, BAD, 4'd0, 5'b10010, "bad_fetch");
    cyc(1, 1, 0, BAD, 4'd1, 5'b00001, "bad_decode_illegal");

    // addi, mem_ready low outside memory states is ignored
    cyc(1, 1, 0, ADDI, 4'd0, 5'b10010, "addi_fetch");
    cyc(1, 0, 0, ADDI, 4'd1, 5'b00000, "addi_decode");
    cyc(1, 0, 0, ADDI, 4'd9, 5'b00000, "addi_ex");
    cyc(1, 0, 0, ADDI, 4'd10, 5'b00100, "addi_wb");

    // sw with two wait cycles in MEMWR
    cyc(1, 1, 0, SW, 4'd0, 5'b10010, "sw_fetch");
    cyc(1, 1, 0, SW, 4'd1, 5'b00000, "sw_decode");
    cyc(1, 1, 0, SW, 4'd2, 5'b00000, "sw_memadr");
    cyc(1, 0, 0, SW, 4'd5, 5'b01000, "sw_memwr_wait1");
    cyc(1, 0, 0, SW, 4'd5, 5'b01000, "sw_memwr_wait2");
    cyc(1, 1, 0, SW, 4'd5, 5'b01000, "sw_memwr_done");

    // sw abandoned by reset while MemWrite is high
    cyc(1, 1, 0, SW, 4'd0, 5'b10010, "sw2_fetch");
    cyc(1, 1, 0, SW, 4'd1, 5'b00000, "sw2_decode");
    cyc(1, 1, 0, SW, 4'd2, 5'b00000, "sw2_memadr");
    cyc(1, 0, 0, SW, 4'd5, 5'b01000, "sw2_memwr_wait");
    cyc(0, 1, 0, SW, 4'd0, 5'b00000, "reset_mid_memwr");
    cyc(1, 1, 0, JMP, 4'd0, 5'b10010, "post_reset_fetch");
    cyc(1, 1, 0, JMP, 4'd1, 5'b00000, "post_reset_decode");
    cyc(1, 1, 0, JMP, 4'd11, 5'b00010, "post_reset_jump");
    cyc(1, 1, 0, JMP, 4'd0, 5'b10010, "post_reset_fetch2");

    // let the monitor drain, bounded
    for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge clk);
    #1;
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL drain: actual=%0d pending required=0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
